// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b), LSB first, valid/ready on both sides.
// Optional SUB_SIGNED_OVF_EN adds the ovf output (two's-complement overflow of the op).
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               br_q, br_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
`ifdef SUB_SIGNED_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic a0, b0, d_bit, br_next;

    // One full-subtractor bit slice; the borrow ripples through br_q across cycles.
    always_comb begin
        a0      = a_sh_q[0];
        b0      = b_sh_q[0];
        d_bit   = a0 ^ b0 ^ br_q;
        br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        cnt_d       = cnt_q;
        br_d        = br_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
`ifdef SUB_SIGNED_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    res_sh_d   = '0;
                    br_d       = 1'b0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {d_bit, res_sh_q[WIDTH-1:1]};
                br_d     = br_next;
                cnt_d    = cnt_q + CNT_W'(1);
                // Visible result only updates on the final bit, so diff never shows a partial value.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d      = {d_bit, res_sh_q[WIDTH-1:1]};
                    bout_d      = br_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SUB_SIGNED_OVF_EN
                    // On the last slice a0/b0 are the operand sign bits and d_bit the result sign.
                    ovf_d       = (a0 != b0) && (d_bit != a0);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): directed vector table, backpressure and reset
// sequences, then randomized ops against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       bout;
`ifdef SUB_SIGNED_OVF_EN
    logic       ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic vec_t model(input logic [3:0] ta, input logic [3:0] tb);
        vec_t v;
        int   sa, sb, sd;
        v.a    = ta;
        v.b    = tb;
        v.diff = 4'((int'(ta) - int'(tb) + 16) % 16);
        v.bout = (int'(ta) < int'(tb));
        sa     = ta[3] ? int'(ta) - 16 : int'(ta);
        sb     = tb[3] ? int'(tb) - 16 : int'(tb);
        sd     = sa - sb;
        v.ovf  = (sd > 7) || (sd < -8);
        return v;
    endfunction

    // Called and returning at a negedge. Holds out_ready low for 'hold' cycles in DONE.
    task automatic run_op(input string name, input vec_t v, input int hold);
        int lat;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = v.a;
        b         = v.b;
        check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " diff"}, 32'(diff), 32'(v.diff));
        check({name, " bout"}, 32'(bout), 32'(v.bout));
`ifdef SUB_SIGNED_OVF_EN
        check({name, " ovf"}, 32'(ovf), 32'(v.ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a        = 4'($urandom);
            b        = 4'($urandom);
            @(negedge clk);
            check({name, " hold {ov,ir,diff,bout}"}, 32'({out_valid, in_ready, diff, bout}),
                  32'({1'b1, 1'b0, v.diff, v.bout}));
`ifdef SUB_SIGNED_OVF_EN
            check({name, " hold ovf"}, 32'(ovf), 32'(v.ovf));
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, " back to idle {ov,ir}"}, 32'({out_valid, in_ready}), 32'b01);
        check({name, " diff retained"}, 32'(diff), 32'(v.diff));
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{a: 4'b0110, b: 4'b0001, diff: 4'b0101, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 4'b0001, b: 4'b0110, diff: 4'b1011, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 4'b0000, b: 4'b0000, diff: 4'b0000, bout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 4'b1000, b: 4'b1001, diff: 4'b1111, bout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 4'b1111, b: 4'b1111, diff: 4'b0000, bout: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 4'b1000, b: 4'b0001, diff: 4'b0111, bout: 1'b0, ovf: 1'b1};
        vecs[6] = '{a: 4'b0111, b: 4'b1000, diff: 4'b1111, bout: 1'b1, ovf: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 4'd0;
        b         = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset {ov,ir,diff,bout}", 32'({out_valid, in_ready, diff, bout}),
              32'({1'b0, 1'b1, 4'b0000, 1'b0}));
`ifdef SUB_SIGNED_OVF_EN
        check("reset ovf", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], 0);
        end

        // Backpressure: 10 cycles of out_ready low with in_valid pounding.
        run_op("backpressure", vecs[1], 10);

        // Reset during the second SHIFT cycle aborts the op and clears the result.
        in_valid = 1'b1;
        a        = 4'b1001;
        b        = 4'b0010;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort {ov,ir,diff,bout}", 32'({out_valid, in_ready, diff, bout}),
              32'({1'b0, 1'b1, 4'b0000, 1'b0}));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort no result", 32'({out_valid, in_ready}), 32'b01);
        end
        run_op("after abort", vecs[0], 0);

        for (int i = 0; i < 150; i++) begin
            vec_t rv;
            rv = model(4'($urandom), 4'($urandom));
            run_op($sformatf("rand%0d", i), rv, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
